// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared constants and FSM state type for the instruction-memory loader
package imem_loader_pkg;

    localparam int IMEM_ADDR_W    = 6;
    localparam int IMEM_DATA_W    = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_COLLECT,
        ST_WRITE,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/imem_word_assembler.sv
// rtl/imem_word_assembler.sv - byte-to-word shift register, byte index and XOR checksum
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,     // length byte accepted: start of a new load
    input  logic                   shift_en,  // data byte accepted
    input  logic                   idx_clr,   // word written, begin the next one
    input  logic [7:0]             byte_in,
    output logic [IMEM_DATA_W-1:0] word_next, // word as it will be after this cycle's shift
    output logic [7:0]             checksum,
    output logic                   last_byte  // the byte being accepted completes a word
);

    logic [IMEM_DATA_W-1:0] word_q, word_d;
    logic [1:0]             idx_q, idx_d;
    logic [7:0]             chk_q, chk_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        chk_d  = chk_q;
        if (clear) begin
            word_d = '0;
            idx_d  = '0;
            chk_d  = '0;
        end else begin
            if (shift_en) begin
                // Bytes arrive MSB first, so each one enters at the low end.
                word_d = {word_q[IMEM_DATA_W-9:0], byte_in};
                chk_d  = chk_q ^ byte_in;
                idx_d  = idx_q + 2'd1;
            end
            if (idx_clr) begin
                idx_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            idx_q  <= '0;
            chk_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
            chk_q  <= chk_d;
        end
    end

    assign word_next = word_d;
    assign checksum  = chk_q;
    assign last_byte = (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a length/data/checksum byte stream into instruction memory
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              WE,
    output logic [ADDR_W-1:0] WA,
    output logic [DATA_W-1:0] WD,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_reset
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              byte_ready_q, byte_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_reset_q, cpu_reset_d;

    logic              xfer;
    logic [DATA_W-1:0] word_next;
    logic [7:0]        checksum;
    logic              last_byte;

    assign xfer = byte_valid && byte_ready_q;

    imem_word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     ((state_q == ST_LEN) && xfer),
        .shift_en  ((state_q == ST_COLLECT) && xfer),
        .idx_clr   (state_q == ST_WRITE),
        .byte_in   (byte_data),
        .word_next (word_next),
        .checksum  (checksum),
        .last_byte (last_byte)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        wa_d    = wa_q;
        wd_d    = wd_q;

        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_LEN;
            ST_LEN: begin
                if (xfer) begin
                    // Keep the last address rather than N: L=0 and L=64 both
                    // give 63, and the compare never needs an extra bit.
                    last_d  = byte_data[ADDR_W-1:0] - ADDR_W'(1);
                    addr_d  = '0;
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: if (xfer && last_byte) state_d = ST_WRITE;
            ST_WRITE: begin
                if (addr_q == last_q) begin
                    state_d = ST_CHK;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = ST_COLLECT;
                end
            end
            ST_CHK: if (xfer) state_d = (byte_data == checksum) ? ST_DONE : ST_ERR;
            ST_DONE, ST_ERR: if (start) state_d = ST_LEN;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so the registered copies
        // line up with the state register.
        byte_ready_d = (state_d == ST_LEN) || (state_d == ST_COLLECT) || (state_d == ST_CHK);
        we_d         = (state_d == ST_WRITE);
        busy_d       = byte_ready_d || we_d;
        done_d       = (state_d == ST_DONE);
        error_d      = (state_d == ST_ERR);
        cpu_reset_d  = (state_d != ST_DONE);
        if (state_d == ST_WRITE) begin
            wa_d = addr_q;
            wd_d = word_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            last_q       <= '0;
            byte_ready_q <= 1'b0;
            we_q         <= 1'b0;
            wa_q         <= '0;
            wd_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            last_q       <= last_d;
            byte_ready_q <= byte_ready_d;
            we_q         <= we_d;
            wa_q         <= wa_d;
            wd_q         <= wd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_reset_q  <= cpu_reset_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign WE         = we_q;
    assign WA         = wa_q;
    assign WD         = wd_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign cpu_reset  = cpu_reset_q;

endmodule
